// File: rtl/greedy_token_encoder.sv
// Greedy longest-match tokenizer: walks a NUL-separated vocabulary for each input position
// and streams the longest matching entry index (or UNK_ID) over a valid/ready handshake.
module greedy_token_encoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] vocab_addr,
  input  logic [DATA_WIDTH-1:0] vocab_data,
  output logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic [ID_WIDTH-1:0]   tok_id,
  output logic [ADDR_WIDTH-1:0] tok_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]   UNK_ID   = '1;
  localparam logic [ID_WIDTH-1:0]   ID_ONE   = ID_WIDTH'(1);

  // Each *_REQ state holds a freshly registered address for one cycle; the
  // matching data-phase state consumes the returned character.
  typedef enum logic [3:0] {
    IDLE,
    END_REQ,
    END_CMP,
    ENT_REQ,
    ENT_CMP,
    CMP_REQ,
    CMP,
    SKIP_REQ,
    SKIP,
    EMIT,
    DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] vocab_addr_q;
  logic [ADDR_WIDTH-1:0] input_addr_q;
  logic [ADDR_WIDTH-1:0] pos_q;
  logic [ADDR_WIDTH-1:0] k_q;
  logic [ADDR_WIDTH-1:0] best_len_q;
  logic [ID_WIDTH-1:0]   best_id_q;
  logic [ID_WIDTH-1:0]   entry_q;
  logic                  tok_valid_q;
  logic [ID_WIDTH-1:0]   tok_id_q;
  logic [ADDR_WIDTH-1:0] tok_len_q;
  logic                  done_q;
  logic                  error_q;

  logic [DATA_WIDTH-1:0] in_char_d;
  logic                  in_nul_d;
  logic                  vocab_nul_d;
  logic [ADDR_WIDTH:0]   vnext_d;
  logic [ID_WIDTH-1:0]   entry_next_d;
  logic                  adv_err_d;
  logic [ADDR_WIDTH:0]   pos_sum_d;

  // The last input address is never read as data; it always acts as a terminator.
  assign in_char_d    = (input_addr_q == MAX_ADDR) ? '0 : input_data;
  assign in_nul_d     = (in_char_d == '0);
  assign vocab_nul_d  = (vocab_data == '0);
  assign vnext_d      = {1'b0, vocab_addr_q} + {1'b0, ADDR_ONE};
  assign entry_next_d = entry_q + ID_ONE;
  assign adv_err_d    = vnext_d[ADDR_WIDTH] || (entry_next_d == UNK_ID);
  assign pos_sum_d    = {1'b0, pos_q} + {1'b0, tok_len_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vocab_addr_q <= '0;
      input_addr_q <= '0;
      pos_q        <= '0;
      k_q          <= '0;
      best_len_q   <= '0;
      best_id_q    <= '0;
      entry_q      <= '0;
      tok_valid_q  <= 1'b0;
      tok_id_q     <= '0;
      tok_len_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            pos_q        <= '0;
            k_q          <= '0;
            input_addr_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            state_q      <= END_REQ;
          end
        end

        END_REQ: state_q <= END_CMP;

        END_CMP: begin
          if (in_nul_d) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            entry_q      <= '0;
            best_len_q   <= '0;
            best_id_q    <= UNK_ID;
            vocab_addr_q <= '0;
            state_q      <= ENT_REQ;
          end
        end

        ENT_REQ: state_q <= ENT_CMP;

        ENT_CMP: begin
          if (vocab_nul_d) begin
            tok_valid_q <= 1'b1;
            tok_id_q    <= best_id_q;
            tok_len_q   <= (best_len_q == '0) ? ADDR_ONE : best_len_q;
            state_q     <= EMIT;
          end else begin
            // vocab_addr_q already points at the entry start; re-fetch it alongside input[pos].
            k_q          <= '0;
            input_addr_q <= pos_q;
            state_q      <= CMP_REQ;
          end
        end

        CMP_REQ: state_q <= CMP;

        CMP: begin
          if (vocab_nul_d) begin
            if (k_q > best_len_q) begin
              best_len_q <= k_q;
              best_id_q  <= entry_q;
            end
            if (adv_err_d) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              vocab_addr_q <= vnext_d[ADDR_WIDTH-1:0];
              entry_q      <= entry_next_d;
              state_q      <= ENT_REQ;
            end
          end else if (vnext_d[ADDR_WIDTH]) begin
            // A non-NUL character at the last vocab address can never be terminated.
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (vocab_data == in_char_d) begin
            k_q          <= k_q + ADDR_ONE;
            vocab_addr_q <= vnext_d[ADDR_WIDTH-1:0];
            input_addr_q <= input_addr_q + ADDR_ONE;
            state_q      <= CMP_REQ;
          end else begin
            vocab_addr_q <= vnext_d[ADDR_WIDTH-1:0];
            state_q      <= SKIP_REQ;
          end
        end

        SKIP_REQ: state_q <= SKIP;

        SKIP: begin
          if (vocab_nul_d ? adv_err_d : vnext_d[ADDR_WIDTH]) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (vocab_nul_d) begin
            vocab_addr_q <= vnext_d[ADDR_WIDTH-1:0];
            entry_q      <= entry_next_d;
            state_q      <= ENT_REQ;
          end else begin
            vocab_addr_q <= vnext_d[ADDR_WIDTH-1:0];
            state_q      <= SKIP_REQ;
          end
        end

        EMIT: begin
          if (tok_ready) begin
            tok_valid_q <= 1'b0;
            if (pos_sum_d[ADDR_WIDTH]) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              pos_q        <= pos_sum_d[ADDR_WIDTH-1:0];
              input_addr_q <= pos_sum_d[ADDR_WIDTH-1:0];
              k_q          <= '0;
              state_q      <= END_REQ;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign vocab_addr = vocab_addr_q;
  assign input_addr = input_addr_q;
  assign tok_valid  = tok_valid_q;
  assign tok_id     = tok_id_q;
  assign tok_len    = tok_len_q;
  assign done       = done_q;
  assign error      = error_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_greedy_token_encoder.sv
// Scoreboard bench for greedy_token_encoder: directed vocab/input images with hand-derived token lists.
module tb_greedy_token_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vocab_addr;
  logic [7:0] vocab_data;
  logic [3:0] input_addr;
  logic [7:0] input_data;
  logic       tok_valid;
  logic       tok_ready;
  logic [3:0] tok_id;
  logic [3:0] tok_len;
  logic       busy;
  logic       done;
  logic       error;

  greedy_token_encoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vocab_addr(vocab_addr), .vocab_data(vocab_data),
    .input_addr(input_addr), .input_data(input_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_id(tok_id), .tok_len(tok_len),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [7:0] vmem [16];
  logic [7:0] imem [16];

  always @(posedge clk) begin
    vocab_data <= vmem[vocab_addr];
    input_data <= imem[input_addr];
  end

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] len;
  } tok_t;

  tok_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_tok(input int id, input int len);
    tok_t t;
    t.id  = 4'(id);
    t.len = 4'(len);
    exp_q.push_back(t);
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid&&ready at the falling edge.
  initial begin
    tok_t t;
    forever begin
      @(negedge clk);
      if (tok_valid && tok_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_token: got id=%0d len=%0d expected none", tok_id, tok_len);
        end else begin
          t = exp_q.pop_front();
          $display("token id=%0d len=%0d (expected id=%0d len=%0d)", tok_id, tok_len, t.id, t.len);
          check("tok_id", int'(tok_id), int'(t.id));
          check("tok_len", int'(tok_len), int'(t.len));
        end
      end
    end
  end

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) begin
      vmem[i] = 8'h00;
      imem[i] = 8'h00;
    end
  endtask

  // "a\0ab\0b\0\0" -> entries 0:"a" 1:"ab" 2:"b"
  task automatic std_vocab();
    vmem[0] = "a"; vmem[1] = 8'h00;
    vmem[2] = "a"; vmem[3] = "b"; vmem[4] = 8'h00;
    vmem[5] = "b"; vmem[6] = 8'h00; vmem[7] = 8'h00;
  endtask

  task automatic input_abab();
    imem[0] = "a"; imem[1] = "b"; imem[2] = "a"; imem[3] = "b"; imem[4] = 8'h00;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_err);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, int'(done), 1);
    check({name, "_error"}, int'(error), exp_err);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_pending"}, exp_q.size(), 0);
    $display("%s: done=%0d error=%0d after %0d cycles", name, done, error, n);
  endtask

  initial begin
    int x0;
    int n;
    rst = 1'b1;
    start = 1'b0;
    tok_ready = 1'b1;
    clear_mems();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tok_valid", int'(tok_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_vocab_addr", int'(vocab_addr), 0);
    check("rst_input_addr", int'(input_addr), 0);

    // Longest match "ab" wins over "a" twice.
    std_vocab();
    input_abab();
    push_tok(1, 2);
    push_tok(1, 2);
    pulse_start();
    wait_done("abab", 0);

    // 'c' matches nothing -> UNK with length 1.
    imem[0] = "a"; imem[1] = "c"; imem[2] = 8'h00;
    push_tok(0, 1);
    push_tok(15, 1);
    pulse_start();
    wait_done("ac", 0);

    // Empty input finishes quickly without tokens.
    imem[0] = 8'h00;
    x0 = xfers;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check("empty_done", int'(done), 1);
    check("empty_busy", int'(busy), 0);
    check("empty_xfers", xfers - x0, 0);
    $display("empty: done=%0d busy=%0d", done, busy);

    // Backpressure: token must hold stable while ready is low.
    imem[0] = "a"; imem[1] = "b"; imem[2] = 8'h00;
    tok_ready = 1'b0;
    x0 = xfers;
    push_tok(1, 2);
    pulse_start();
    n = 0;
    while (!tok_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", int'(tok_valid), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(tok_valid), 1);
      check("bp_hold_id", int'(tok_id), 1);
      check("bp_hold_len", int'(tok_len), 2);
    end
    @(posedge clk); #1 tok_ready = 1'b1;
    wait_done("backpressure", 0);
    check("bp_xfers", xfers - x0, 1);

    // Vocab without any terminator overflows the address space.
    for (int i = 0; i < 16; i++) vmem[i] = 8'h61;
    input_abab();
    x0 = xfers;
    pulse_start();
    wait_done("overflow", 1);
    check("overflow_xfers", xfers - x0, 0);
    pulse_start();
    @(negedge clk);
    check("restart_done_clr", int'(done), 0);
    check("restart_error_clr", int'(error), 0);
    wait_done("overflow2", 1);

    // Reset in the middle of the first COMPARE, then a clean rerun.
    clear_mems();
    std_vocab();
    input_abab();
    pulse_start();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_tok_valid", int'(tok_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_error", int'(error), 0);
    check("midrst_vocab_addr", int'(vocab_addr), 0);
    check("midrst_input_addr", int'(input_addr), 0);
    check("midrst_tok_id", int'(tok_id), 0);
    check("midrst_tok_len", int'(tok_len), 0);
    repeat (3) @(negedge clk);
    check("midrst_idle_busy", int'(busy), 0);
    push_tok(1, 2);
    push_tok(1, 2);
    pulse_start();
    wait_done("rerun", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/greedy_token_encoder.md
Name: greedy_token_encoder

Overview:
- Streaming tokenizer: greedy longest-match of a NUL-terminated input string against a vocabulary of back-to-back NUL-terminated entries.
- Emits one token ID per match over a valid/ready stream; ID is the entry index.
- Unmatched bytes are emitted as UNK_ID with length 1.
- Parametrised successor of the single-match matcher. Adds longest-match selection, multi-token output, backpressure and error reporting. Sits between the vocab/input memories and downstream embedding logic.

Parameters:
- ADDR_WIDTH, 4: address width of both memories; also width of tok_len.
- DATA_WIDTH, 8: character width; all-zeros is the NUL terminator.
- ID_WIDTH, 4: token ID width. UNK_ID = 2**ID_WIDTH-1 is reserved.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: pulse; begins encoding from input address 0. Ignored unless in IDLE or DONE.
- vocab_addr, out, ADDR_WIDTH: registered vocab read address.
- vocab_data, in, DATA_WIDTH: vocab char; valid the cycle after vocab_addr is driven.
- input_addr, out, ADDR_WIDTH: registered input read address.
- input_data, in, DATA_WIDTH: input char; valid the cycle after input_addr is driven.
- tok_valid, out, 1: token available.
- tok_ready, in, 1: downstream accepts.
- tok_id, out, ID_WIDTH: token ID.
- tok_len, out, ADDR_WIDTH: characters consumed by the token.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: level; high in DONE until the next start or rst.
- error, out, 1: sticky until next start or rst.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation): state=IDLE, all outputs 0, internal pos/best registers 0.
- Every character fetch takes 2 cycles: REQ (drive address) then CMP (use data).

States:
- IDLE: wait for start.
- CHK_END: read input[pos].
  - NUL -> DONE.
  - Otherwise reset entry=0, vaddr=0, best_len=0, best_id=UNK_ID -> ENT_START.
- ENT_START: read vocab[vaddr].
  - NUL at entry start marks end of table -> EMIT.
  - Otherwise k=0 -> COMPARE.
- COMPARE: compare vocab[vaddr+k] with input[pos+k].
  - Vocab char NUL means a full entry match of length k. If k > best_len, record best_len=k and best_id=entry. Then vaddr += k+1, entry++ -> ENT_START.
  - Chars equal and non-NUL: k++, stay in COMPARE.
  - Mismatch, or input NUL first: -> SKIP.
- SKIP: advance vaddr until a vocab NUL is read, then vaddr++, entry++ -> ENT_START.
- EMIT: tok_valid=1 with tok_id=best_id and tok_len=max(best_len,1).
  - Outputs are held stable while tok_valid && !tok_ready.
  - On tok_valid && tok_ready: pos += tok_len, tok_valid=0 -> CHK_END.
- DONE: done=1, busy=0. start -> CHK_END with pos=0 and done, error cleared.

Rules:
- Tie-break: strictly-greater update, so among equal lengths the lowest entry index wins.
- tok_valid never drops without a handshake. tok_ready while tok_valid=0 has no effect.
- Vocab overflow: vaddr would need to pass 2**ADDR_WIDTH-1 without a terminator, or entry reaches UNK_ID. Then error=1 -> DONE, and no further tokens are emitted.
- Input overflow: pos+k reaching 2**ADDR_WIDTH-1 is treated as a NUL. pos wrapping past the max address -> error=1, DONE.
- start while busy: ignored.
- rst asserted the same cycle as start: rst wins.

Test Plan:
- Vocab "a\0ab\0b\0\0" (IDs 0,1,2), input "abab\0", tok_ready=1, start -> tokens (id1,len2), (id1,len2); then done=1, error=0.
- Same vocab, input "ac\0" -> (id0,len1), (id15,len1); done=1.
- Input "\0" -> no tok_valid; done=1 within 4 cycles of start; busy low after.
- Input "ab\0", tok_ready held low 6 cycles in EMIT -> tok_valid=1 and tok_id=1/tok_len=2 stable across all 6 cycles; exactly one token transferred on release.
- Vocab filled with 'a' and no NUL (16 entries of 0x61) -> error=1, done=1, no token emitted. A subsequent start clears both flags.
- rst pulsed while in COMPARE on input "abab\0" -> next cycle all outputs 0 and state IDLE. A new start reproduces the first scenario exactly.
